// File: rtl/icebrk_abi_pkg.sv
// Shared constants and types for the icebrk ABI host-side initiator.
package icebrk_abi_pkg;

   localparam int unsigned VID_W  = 14;
   localparam int unsigned DATA_W = 32;

   localparam logic [VID_W-1:0] VID_NOP = '0;

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StRecover,
      StResp
   } abi_state_t;

   typedef struct packed {
      logic              read;
      logic [VID_W-1:0]  vid;
      logic [DATA_W-1:0] data;
   } abi_req_t;

   function automatic logic is_nop(input logic [VID_W-1:0] v);
      return v == VID_NOP;
   endfunction

endpackage

// File: rtl/icebrk_abi_master_if.sv
// Host request/response port plus the core-side vid/read/in/out/wait_ bus.
interface icebrk_abi_master_if;
   import icebrk_abi_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_read;
   logic [VID_W-1:0]  req_vid;
   logic [DATA_W-1:0] req_data;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;

   logic [VID_W-1:0]  vid;
   logic              read;
   logic [DATA_W-1:0] in;
   logic [DATA_W-1:0] out;
   logic              wait_;

   modport master (
      input  req_valid, req_read, req_vid, req_data, rsp_ready, out, wait_,
      output req_ready, rsp_valid, rsp_data, rsp_err, vid, read, in
   );

   modport slave (
      output req_valid, req_read, req_vid, req_data, rsp_ready, out, wait_,
      input  req_ready, rsp_valid, rsp_data, rsp_err, vid, read, in
   );

endinterface

// File: rtl/icebrk_stall_timer.sv
// Saturating stall counter; expired_o flags the enabled edge that brings the count to TIMEOUT.
module icebrk_stall_timer #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);
   localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != CntMax)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // TIMEOUT of zero disables expiry entirely; CntMax is then 0 so the count also stays put.
   assign expired_o = (TIMEOUT != 0) && en_i && !clear_i && (cnt_q == CntLast);

endmodule

// File: rtl/icebrk_abi_master.sv
// Single-outstanding initiator: host valid/ready request -> one ABI access -> one response.
module icebrk_abi_master
   import icebrk_abi_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1024
) (
   input logic                 clk,
   input logic                 rst_n,
   icebrk_abi_master_if.master bus_io
);

   abi_state_t        state_q, state_d;
   abi_req_t          req_q, req_d;
   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;
   logic [VID_W-1:0]  vid_q, vid_d;
   logic              read_q, read_d;
   logic [DATA_W-1:0] in_q, in_d;

   logic req_hs;
   logic presented;
   logic expired;
   logic done;
   logic drive;

   // The first ACCESS cycle only loads the bus register; wait_ counts once vid is on the bus.
   assign req_hs    = bus_io.req_valid && req_ready_q;
   assign presented = (state_q == StAccess) && !is_nop(vid_q);
   assign done      = presented && (!bus_io.wait_ || expired);

   icebrk_stall_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_stall_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (!presented),
      .en_i      (presented && bus_io.wait_),
      .expired_o (expired)
   );

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      unique case (state_q)
         StIdle: begin
            if (req_hs) begin
               req_d.read = bus_io.req_read;
               req_d.vid  = bus_io.req_vid;
               req_d.data = bus_io.req_data;
               if (is_nop(bus_io.req_vid)) begin
                  state_d    = StResp;
                  rsp_err_d  = 1'b1;
                  rsp_data_d = '0;
               end else begin
                  state_d = StAccess;
               end
            end
         end
         StAccess: begin
            if (done) begin
               state_d = StRecover;
               if (!bus_io.wait_) begin
                  rsp_err_d  = 1'b0;
                  rsp_data_d = req_q.read ? bus_io.out : '0;
               end else begin
                  rsp_err_d  = 1'b1;
                  rsp_data_d = '0;
               end
            end
         end
         StRecover: begin
            state_d = StResp;
         end
         StResp: begin
            if (bus_io.rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      drive       = (state_q == StAccess) && !done;
      req_ready_d = (state_d == StIdle);
      rsp_valid_d = (state_d == StResp);
      vid_d       = drive ? req_q.vid : VID_NOP;
      read_d      = drive && req_q.read;
      in_d        = drive ? req_q.data : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         req_q       <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         vid_q       <= VID_NOP;
         read_q      <= 1'b0;
         in_q        <= '0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         vid_q       <= vid_d;
         read_q      <= read_d;
         in_q        <= in_d;
      end
   end

   assign bus_io.req_ready = req_ready_q;
   assign bus_io.rsp_valid = rsp_valid_q;
   assign bus_io.rsp_data  = rsp_data_q;
   assign bus_io.rsp_err   = rsp_err_q;
   assign bus_io.vid       = vid_q;
   assign bus_io.read      = read_q;
   assign bus_io.in        = in_q;

endmodule

// File: tb/tb_icebrk_abi_master.sv
// Directed bench: one DUT with an 8-cycle timeout, one with the timeout disabled.
module tb_icebrk_abi_master;
   import icebrk_abi_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   int   n;

   icebrk_abi_master_if bus ();
   icebrk_abi_master_if bus0 ();

   icebrk_abi_master #(
      .TIMEOUT (8)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus)
   );

   icebrk_abi_master #(
      .TIMEOUT (0)
   ) dut0 (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_read   = 1'b0;
      bus.req_vid    = '0;
      bus.req_data   = '0;
      bus.rsp_ready  = 1'b0;
      bus.out        = '0;
      bus.wait_      = 1'b0;
      bus0.req_valid = 1'b0;
      bus0.req_read  = 1'b0;
      bus0.req_vid   = '0;
      bus0.req_data  = '0;
      bus0.rsp_ready = 1'b0;
      bus0.out       = '0;
      bus0.wait_     = 1'b0;

      // Reset values
      step();
      step();
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_bus", {bus.vid, bus.read, bus.rsp_valid, bus.rsp_err}, 64'd0);
      chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
      rst_n = 1'b1;
      chk("rel_req_ready_first", 64'(bus.req_ready), 64'd0);
      step();
      chk("rel_req_ready_then", 64'(bus.req_ready), 64'd1);

      // Read vid=5, no stall
      bus.out       = 32'hDEADBEEF;
      bus.req_valid = 1'b1;
      bus.req_read  = 1'b1;
      bus.req_vid   = 14'd5;
      step();
      bus.req_valid = 1'b0;
      chk("rd_e0_vid", 64'(bus.vid), 64'd0);
      chk("rd_e0_ready", 64'(bus.req_ready), 64'd0);
      step();
      chk("rd_e1_bus", {bus.vid, bus.read}, {14'd5, 1'b1});
      step();
      chk("rd_e2_nop", 64'(bus.vid), 64'd0);
      chk("rd_e2_valid", 64'(bus.rsp_valid), 64'd0);
      bus.out = 32'h0BADF00D;
      step();
      chk("rd_e3_valid", 64'(bus.rsp_valid), 64'd1);
      chk("rd_e3_data", 64'(bus.rsp_data), 64'hDEADBEEF);
      chk("rd_e3_err", 64'(bus.rsp_err), 64'd0);
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      chk("rd_done_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rd_done_ready", 64'(bus.req_ready), 64'd1);

      // Write vid=9 with four stalled edges
      bus.wait_     = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_read  = 1'b0;
      bus.req_vid   = 14'd9;
      bus.req_data  = 32'h12345678;
      step();
      bus.req_valid = 1'b0;
      n = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (bus.vid == 14'd9 && bus.in == 32'h12345678 && !bus.read) n++;
         if (i == 2) chk("wr_stall_ready", 64'(bus.req_ready), 64'd0);
         if (i == 4) bus.wait_ = 1'b0;
      end
      chk("wr_stable_cycles", 64'(n), 64'd5);
      step();
      chk("wr_recover_nop", {bus.vid, bus.in}, 64'd0);
      chk("wr_recover_valid", 64'(bus.rsp_valid), 64'd0);
      step();
      chk("wr_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, {1'b1, 1'b0, 32'h0});
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;

      // Timeout after eight stalled edges
      bus.wait_     = 1'b1;
      bus.out       = 32'hFFFF0001;
      bus.req_valid = 1'b1;
      bus.req_read  = 1'b1;
      bus.req_vid   = 14'd3;
      step();
      bus.req_valid = 1'b0;
      for (int i = 0; i < 8; i++) step();
      chk("to_edge8_vid", 64'(bus.vid), 64'd3);
      step();
      chk("to_edge9_released", 64'(bus.vid), 64'd0);
      step();
      chk("to_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, {1'b1, 1'b1, 32'h0});
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      bus.wait_     = 1'b0;

      // TIMEOUT=0: stall indefinitely, then complete
      bus0.wait_     = 1'b1;
      bus0.out       = 32'hA5A5_5A5A;
      bus0.req_valid = 1'b1;
      bus0.req_read  = 1'b1;
      bus0.req_vid   = 14'd7;
      step();
      bus0.req_valid = 1'b0;
      for (int i = 0; i < 2000; i++) step();
      chk("nt_still_waiting", {bus0.vid, bus0.rsp_valid}, {14'd7, 1'b0});
      bus0.wait_ = 1'b0;
      step();
      chk("nt_released", 64'(bus0.vid), 64'd0);
      step();
      chk("nt_rsp", {bus0.rsp_valid, bus0.rsp_err, bus0.rsp_data}, {1'b1, 1'b0, 32'hA5A55A5A});
      bus0.rsp_ready = 1'b1;
      step();
      bus0.rsp_ready = 1'b0;

      // vid=0 request: immediate error, no bus access
      bus.req_valid = 1'b1;
      bus.req_read  = 1'b0;
      bus.req_vid   = 14'd0;
      bus.req_data  = 32'h55AA55AA;
      step();
      bus.req_valid = 1'b0;
      chk("nop_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, {1'b1, 1'b1, 32'h0});
      chk("nop_bus", 64'(bus.vid), 64'd0);
      bus.rsp_ready = 1'b1;
      step();
      chk("nop_done", {bus.rsp_valid, bus.req_ready}, 64'b01);

      // Back-to-back with rsp_ready held high
      bus.out       = 32'h0000_1111;
      bus.req_valid = 1'b1;
      bus.req_read  = 1'b1;
      bus.req_vid   = 14'h11;
      step();
      begin
         logic [15:0] exp_tab [10];
         exp_tab = '{{1'b0, 1'b0, 14'h00}, {1'b0, 1'b0, 14'h11}, {1'b0, 1'b0, 14'h00},
                     {1'b0, 1'b1, 14'h00}, {1'b1, 1'b0, 14'h00}, {1'b0, 1'b0, 14'h00},
                     {1'b0, 1'b0, 14'h22}, {1'b0, 1'b0, 14'h00}, {1'b0, 1'b1, 14'h00},
                     {1'b1, 1'b0, 14'h00}};
         for (int i = 0; i < 10; i++) begin
            if (i > 0) step();
            if (i == 0) begin
               bus.req_read = 1'b0;
               bus.req_vid  = 14'h22;
               bus.req_data = 32'hCAFE0022;
            end
            if (i == 5) bus.req_valid = 1'b0;
            chk($sformatf("b2b_cyc%0d", i), {bus.req_ready, bus.rsp_valid, bus.vid},
                64'(exp_tab[i]));
            if (i == 3) chk("b2b_rsp1_data", 64'(bus.rsp_data), 64'h1111);
            if (i == 8) chk("b2b_rsp2_data", 64'(bus.rsp_data), 64'h0);
         end
      end
      bus.rsp_ready = 1'b0;

      // Reset during a stalled access
      bus.wait_     = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_read  = 1'b1;
      bus.req_vid   = 14'h33;
      step();
      bus.req_valid = 1'b0;
      step();
      step();
      chk("rst_mid_presented", 64'(bus.vid), 64'h33);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_vid", 64'(bus.vid), 64'd0);
      chk("rst_mid_ready", 64'(bus.req_ready), 64'd0);
      step();
      rst_n     = 1'b1;
      bus.wait_ = 1'b0;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (bus.rsp_valid || bus.vid != '0) n++;
      end
      chk("rst_mid_no_rsp", 64'(n), 64'd0);
      bus.out       = 32'hCAFEF00D;
      bus.req_valid = 1'b1;
      bus.req_read  = 1'b1;
      bus.req_vid   = 14'd5;
      step();
      bus.req_valid = 1'b0;
      step();
      chk("post_rst_bus", {bus.vid, bus.read}, {14'd5, 1'b1});
      step();
      step();
      chk("post_rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, {1'b1, 1'b0, 32'hCAFEF00D});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
